disp_wr_arbiter: RTL and testbench
==================================

DISP_WR_ARBITER -- requirements
Module: disp_wr_arbiter

Interface
REQ-001 The block SHALL have parameter CLR_VALUE, default 4'h0, which is the digit value written to every digit by the clear sequence.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req0_valid, input, 1 bit: requester 0 has a digit write pending.
REQ-005 The block SHALL have ports req0_sel (input, 3 bits) and req0_num (input, 4 bits): requester 0 digit index and digit value.
REQ-006 The block SHALL have port req0_ready, output, 1 bit: requester 0 write accepted this cycle.
REQ-007 The block SHALL have ports req1_valid, req1_sel, req1_num and req1_ready, with the same directions and widths as requester 0, for requester 1.
REQ-008 The block SHALL have port clear_req, input, 1 bit: request to clear all 8 digits; present only when DISP_CLEAR_EN is defined.
REQ-009 The block SHALL have port write, output, 1 bit: one-cycle write strobe to the display digit memory.
REQ-010 The block SHALL have ports sel (output, 3 bits) and num (output, 4 bits): digit index and value accompanying write.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, WRITE and CLEAR; CLEAR exists only with DISP_CLEAR_EN.
REQ-013 In IDLE, the block SHALL accept a request with at least one valid; the matching ready SHALL be high combinationally in that cycle, and sel/num SHALL be registered.
REQ-014 Any cycle with an accepted request SHALL be followed by WRITE for exactly one cycle, then IDLE.
REQ-015 In WRITE, the block SHALL hold write=1 with the captured sel/num, and no ready SHALL be asserted.
REQ-016 Peak throughput SHALL be one write every 2 cycles.
REQ-017 Write latency SHALL be exactly 1 cycle from the ready cycle to the write=1 cycle.
REQ-018 When both valids are high in IDLE, round-robin SHALL apply: grant the requester not granted last.
REQ-019 The last-grant register SHALL update only on acceptance; when one valid is high, that requester SHALL be granted regardless of history.
REQ-020 Requesters SHALL hold valid, sel and num stable until ready; the block SHALL not capture a request whose valid drops before acceptance.
REQ-021 At most one ready SHALL be high in any cycle, and ready SHALL never be high outside IDLE.
REQ-022 With DISP_CLEAR_EN, clear_req high in IDLE SHALL take priority over both requesters and enter CLEAR, with no ready asserted that cycle.
REQ-023 CLEAR SHALL last exactly 8 cycles with write=1, sel=0..7 ascending and num=CLR_VALUE, then return to IDLE.
REQ-024 clear_req SHALL be ignored while in WRITE or CLEAR (not queued); requests SHALL be ignored until IDLE.
REQ-025 When write=0, sel and num SHALL hold their last values.
REQ-026 The 3-bit clear counter SHALL wrap 7->0 on exit.

Reset
REQ-027 On reset=1 at a clock edge, the block SHALL enter IDLE with write=0, sel=0, num=0, busy=0, req0_ready=0, req1_ready=0 and clear counter=0.
REQ-028 On reset, last-grant SHALL be set to 1 so that requester 0 wins the first contention.
REQ-029 Reset SHALL override every state, including mid-WRITE and mid-CLEAR; an aborted write or clear SHALL not resume.
REQ-030 Readies SHALL be 0 during any reset cycle.

Configuration
REQ-031 Macro DISP_CLEAR_EN SHALL control the clear feature.
REQ-032 With DISP_CLEAR_EN defined, the block SHALL include the clear_req port, the CLEAR state, the clear counter and the clear priority.
REQ-033 Without DISP_CLEAR_EN, the block SHALL omit the port and the CLEAR state and behave only as a 2-requester arbiter, with the behaviour otherwise identical.

Structure
REQ-034 Shared package disp_pkg SHALL hold SEL_W=3, NUM_W=4, NUM_DIGITS=8 and the FSM state enum type.
REQ-035 Sub-module rr_arb2 SHALL contain the combinational two-requester round-robin pick from valids plus a last-grant input.
REQ-036 The FSM and output registers SHALL remain in disp_wr_arbiter.

Verification
REQ-037 Reset, then req0 valid with sel=3, num=4'hA -> req0_ready at cycle N, then write=1, sel=3, num=A at N+1, then busy=0 at N+2.
REQ-038 Reset, then both valid (req0 sel=1/num=2, req1 sel=5/num=7) held -> grant order req0, req1, req0, ... with writes every 2 cycles.
REQ-039 Only req1 valid after a req1 grant -> req1 regranted on every IDLE cycle.
REQ-040 With DISP_CLEAR_EN, clear_req and req0 both valid in IDLE -> 8 writes of sel 0..7 with num=0, then req0 accepted at the first IDLE.
REQ-041 Reset asserted in the 4th CLEAR cycle -> next cycle IDLE, write=0, sel=0, and no further clear writes.
REQ-042 clear_req pulsed during WRITE -> ignored, and no CLEAR entry afterward.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared widths and FSM state type for the display digit write arbiter.
// The CLEAR state exists only when DISP_CLEAR_EN is defined.
package disp_pkg;

    localparam int SEL_W      = 3;
    localparam int NUM_W      = 4;
    localparam int NUM_DIGITS = 8;

`ifdef DISP_CLEAR_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1
    } state_e;
`endif

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-requester round-robin pick.
// On contention the requester that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        if (valid_i == 2'b11) begin
            grant_o = last_i ? 2'b01 : 2'b10;
        end else begin
            grant_o = valid_i;
        end
    end

endmodule

// File: rtl/disp_wr_arbiter.sv
// Arbitrates two digit-write requesters onto a single display memory write port.
// Optional clear-all sequence is enabled by defining DISP_CLEAR_EN.
module disp_wr_arbiter
    import disp_pkg::*;
#(
    parameter logic [NUM_W-1:0] CLR_VALUE = 4'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic [NUM_W-1:0] req0_num,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [SEL_W-1:0] req1_sel,
    input  logic [NUM_W-1:0] req1_num,
    output logic             req1_ready,
`ifdef DISP_CLEAR_EN
    input  logic             clear_req,
`endif
    output logic             write,
    output logic [SEL_W-1:0] sel,
    output logic [NUM_W-1:0] num,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic             last_q, last_d;
    logic [1:0]       grant;
`ifdef DISP_CLEAR_EN
    logic [SEL_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

    rr_arb2 u_rr_arb2 (
        .valid_i (reg_valid()),
        .last_i  (last_q),
        .grant_o (grant)
    );

    function automatic logic [1:0] reg_valid();
        return {req1_valid, req0_valid};
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        sel_d      = sel_q;
        num_d      = num_q;
        last_d     = last_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
`ifdef DISP_CLEAR_EN
        clr_cnt_d  = clr_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
`ifdef DISP_CLEAR_EN
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    sel_d     = '0;
                    num_d     = CLR_VALUE;
                    clr_cnt_d = '0;
                end else
`endif
                if (|grant) begin
                    state_d    = ST_WRITE;
                    req0_ready = grant[0];
                    req1_ready = grant[1];
                    sel_d      = grant[1] ? req1_sel : req0_sel;
                    num_d      = grant[1] ? req1_num : req0_num;
                    last_d     = grant[1];
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
`ifdef DISP_CLEAR_EN
            ST_CLEAR: begin
                // Counter wraps 7->0 on the final digit; sel stays on the last digit.
                clr_cnt_d = clr_cnt_q + SEL_W'(1);
                if (clr_cnt_q == SEL_W'(NUM_DIGITS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    sel_d = clr_cnt_q + SEL_W'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (reset) begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            num_q     <= '0;
            last_q    <= 1'b1;
`ifdef DISP_CLEAR_EN
            clr_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            num_q     <= num_d;
            last_q    <= last_d;
`ifdef DISP_CLEAR_EN
            clr_cnt_q <= clr_cnt_d;
`endif
        end
    end

    assign write = (state_q != ST_IDLE);
    assign busy  = (state_q != ST_IDLE);
    assign sel   = sel_q;
    assign num   = num_q;

endmodule

// File: tb/tb_disp_wr_arbiter.sv
// Self-checking bench for disp_wr_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations. Clear scenarios need DISP_CLEAR_EN.
module tb_disp_wr_arbiter;
    import disp_pkg::*;

    localparam logic [3:0] CLR_VAL = 4'h0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [2:0] req0_sel = '0, req1_sel = '0;
    logic [3:0] req0_num = '0, req1_num = '0;
    logic       req0_ready, req1_ready;
    logic       clear_req = 1'b0;
    logic       write, busy;
    logic [2:0] sel;
    logic [3:0] num;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    disp_wr_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_sel   (req0_sel),
        .req0_num   (req0_num),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_sel   (req1_sel),
        .req1_num   (req1_num),
        .req1_ready (req1_ready),
`ifdef DISP_CLEAR_EN
        .clear_req  (clear_req),
`endif
        .write      (write),
        .sel        (sel),
        .num        (num),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of write beats still owed to the display.
    typedef struct {
        logic [2:0] sel;
        logic [3:0] num;
    } wr_t;

    wr_t        pend[$];
    logic [2:0] h_sel = '0;
    logic [3:0] h_num = '0;
    int         last_winner = 1;
    bit         model_ok = 1'b0;

    always @(negedge clk) begin : cmp
        int   win;
        bit   idle;
        logic clr_now;
        wr_t  w;
        idle = (pend.size() == 0);
`ifdef DISP_CLEAR_EN
        clr_now = clear_req;
`else
        clr_now = 1'b0;
`endif
        win = -1;
        if (idle && !reset && !clr_now) begin
            if (req0_valid && req1_valid) win = (last_winner == 0) ? 1 : 0;
            else if (req0_valid)          win = 0;
            else if (req1_valid)          win = 1;
        end
        if (model_ok) begin
            check("m_ready0", req0_ready, win == 0);
            check("m_ready1", req1_ready, win == 1);
            if (idle) begin
                check("m_write", write, 1'b0);
                check("m_busy",  busy,  1'b0);
                check("m_sel",   sel,   h_sel);
                check("m_num",   num,   h_num);
            end else begin
                check("m_write", write, 1'b1);
                check("m_busy",  busy,  1'b1);
                check("m_sel",   sel,   pend[0].sel);
                check("m_num",   num,   pend[0].num);
            end
        end
        if (reset) begin
            pend.delete();
            h_sel       = '0;
            h_num       = '0;
            last_winner = 1;
            model_ok    = 1'b1;
        end else if (!idle) begin
            w     = pend.pop_front();
            h_sel = w.sel;
            h_num = w.num;
        end else if (clr_now) begin
            for (int d = 0; d < 8; d++) pend.push_back('{sel: 3'(d), num: CLR_VAL});
        end else if (win == 0) begin
            pend.push_back('{sel: req0_sel, num: req0_num});
            last_winner = 0;
        end else if (win == 1) begin
            pend.push_back('{sel: req1_sel, num: req1_num});
            last_winner = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single requester: ready, then write one cycle later, then idle.
        repeat (2) step();
        reset = 1'b0;
        req0_valid = 1'b1; req0_sel = 3'd3; req0_num = 4'hA;
        @(negedge clk);
        check("t1_ready0", req0_ready, 1'b1);
        check("t1_busy0",  busy, 1'b0);
        check("t1_rstsel", sel, 3'd0);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        check("t1_write", write, 1'b1);
        check("t1_sel",   sel, 3'd3);
        check("t1_num",   num, 4'hA);
        check("t1_noready", req0_ready, 1'b0);
        step();
        @(negedge clk);
        check("t1_idle", busy, 1'b0);
        check("t1_hold", sel, 3'd3);
        step();

        // Contention after reset: readies blocked during reset, then req0, req1, req0, ...
        reset = 1'b1;
        req0_valid = 1'b1; req0_sel = 3'd1; req0_num = 4'h2;
        req1_valid = 1'b1; req1_sel = 3'd5; req1_num = 4'h7;
        @(negedge clk);
        check("t2_rst_r0", req0_ready, 1'b0);
        check("t2_rst_r1", req1_ready, 1'b0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t2_ready0", req0_ready, (i % 4) == 0);
            check("t2_ready1", req1_ready, (i % 4) == 2);
            check("t2_write",  write, (i % 2) == 1);
            if (i % 4 == 1) check("t2_sel_a", sel, 3'd1);
            if (i % 4 == 3) check("t2_sel_b", sel, 3'd5);
            step();
        end

        // Only req1: regranted on every idle cycle; then contention goes to req0.
        req0_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("t3_ready1", req1_ready, (j % 2) == 0);
            if (j % 2 == 1) check("t3_num", num, 4'h7);
            step();
        end
        req0_valid = 1'b1;
        @(negedge clk);
        check("t3_rr_r0", req0_ready, 1'b1);
        check("t3_rr_r1", req1_ready, 1'b0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("t3_sel", sel, 3'd1);
        step();

        // A valid raised during WRITE and withdrawn before IDLE is never captured.
        req0_valid = 1'b1; req0_sel = 3'd0; req0_num = 4'hF;
        @(negedge clk);
        check("t4_ready0", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_sel = 3'd4; req1_num = 4'h3;
        @(negedge clk);
        check("t4_num", num, 4'hF);
        check("t4_ready1", req1_ready, 1'b0);
        step();
        req1_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("t4_nowrite", write, 1'b0);
            step();
        end

`ifdef DISP_CLEAR_EN
        // Clear beats a pending requester; req0 accepted at the first IDLE afterwards.
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_req = 1'b1;
        req0_valid = 1'b1; req0_sel = 3'd2; req0_num = 4'h4;
        @(negedge clk);
        check("t5_noready", req0_ready, 1'b0);
        step();
        clear_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t5_write", write, 1'b1);
            check("t5_sel",   sel, 3'(k));
            check("t5_num",   num, CLR_VAL);
            step();
        end
        @(negedge clk);
        check("t5_ready0", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        check("t5_wsel", sel, 3'd2);
        check("t5_wnum", num, 4'h4);
        step();

        // Reset in the 4th clear cycle aborts the sequence.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        @(negedge clk);
        check("t6_sel3", sel, 3'd3);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t6_write", write, 1'b0);
        check("t6_sel0",  sel, 3'd0);
        step();
        repeat (9) begin
            @(negedge clk);
            check("t6_nowrite", write, 1'b0);
            step();
        end

        // Clear pulsed during WRITE is dropped.
        req0_valid = 1'b1; req0_sel = 3'd6; req0_num = 4'h1;
        step();
        req0_valid = 1'b0;
        clear_req  = 1'b1;
        @(negedge clk);
        check("t7_sel", sel, 3'd6);
        step();
        clear_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t7_idle", busy, 1'b0);
            step();
        end
`endif

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
